// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package cpu_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      ADDIEX = 4'd8,
      ADDIWB = 4'd9,
      BRANCH = 4'd10,
      JUMP   = 4'd11
   } stateT;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BGTZ = 6'b000111;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [2:0] ALU_ADD  = 3'b111;
   localparam logic [2:0] ALU_GTZ  = 3'b110;
   localparam logic [2:0] ALU_PASS = 3'b101;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   function automatic logic isKnownOp(input logic [5:0] opc);
      return opc inside {OP_ADD, OP_ADDI, OP_LW, OP_SW, OP_BGTZ, OP_J};
   endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational state-to-control decode. Write strobes are held low while
// reset is asserted so nothing commits before the state register clears.
module mc_out_decode
   import cpu_pkg::*;
#(
   parameter int OP_W   = 6,
   parameter int ALUC_W = 3
) (
   input  logic              reset,
   input  stateT             state,
   input  logic [OP_W-1:0]   op,
   input  logic              memReady,
   input  logic              gtz,
   output logic              IorD,
   output logic              MemRead,
   output logic              MemWrite,
   output logic              IRWrite,
   output logic              PCWrite,
   output logic              Branch,
   output logic [1:0]        PCSrc,
   output logic              ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [ALUC_W-1:0] ALUControl,
   output logic              RegDst,
   output logic              MemtoReg,
   output logic              RegWrite,
   output logic              illegal
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      PCSrc      = PCSRC_ALU;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_REG;
      ALUControl = ALUC_W'(ALU_ADD);
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      illegal    = 1'b0;
      case (state)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = memReady;
            PCWrite = memReady;
         end
         DECODE: begin
            ALUSrcB = SRCB_IMMSH;
            illegal = !isKnownOp(6'(op));
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         MEMRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
         end
         MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         MEMWR: begin
            IorD     = 1'b1;
            MemWrite = memReady;
         end
         EXEC:   ALUSrcA = 1'b1;
         ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         ADDIWB: RegWrite = 1'b1;
         BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALUC_W'(ALU_GTZ);
            PCSrc      = PCSRC_ALUOUT;
            Branch     = gtz;
         end
         JUMP: begin
            ALUControl = ALUC_W'(ALU_PASS);
            PCSrc      = PCSRC_JUMP;
            PCWrite    = 1'b1;
         end
         default: ;
      endcase
      // Strobes drop as soon as reset rises, ahead of the synchronous state clear.
      if (reset) begin
         MemWrite = 1'b0;
         RegWrite = 1'b0;
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         Branch   = 1'b0;
         illegal  = 1'b0;
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: state register with next-state logic, plus the
// output decode sub-module.
module multicycle_control
   import cpu_pkg::*;
#(
   parameter int OP_W     = 6,
   parameter int ALUC_W   = 3,
   parameter int MEM_WAIT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [OP_W-1:0]   op,
   input  logic              mem_ready,
   input  logic              gtz,
   output logic              IorD,
   output logic              MemRead,
   output logic              MemWrite,
   output logic              IRWrite,
   output logic              PCWrite,
   output logic              Branch,
   output logic [1:0]        PCSrc,
   output logic              ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [ALUC_W-1:0] ALUControl,
   output logic              RegDst,
   output logic              MemtoReg,
   output logic              RegWrite,
   output logic              illegal,
   output logic [3:0]        state
);

   stateT      curState;
   logic       memReady;
   logic [5:0] opc;

   // With MEM_WAIT=0 the memory is assumed single-cycle and mem_ready is ignored.
   assign memReady = (MEM_WAIT != 0) ? mem_ready : 1'b1;
   assign opc      = 6'(op);
   assign state    = curState;

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (reset) begin
         curState <= FETCH;
      end else begin
         case (curState)
            FETCH:  if (memReady) curState <= DECODE;
            DECODE: begin
               case (opc)
                  OP_ADD:       curState <= EXEC;
                  OP_ADDI:      curState <= ADDIEX;
                  OP_LW, OP_SW: curState <= MEMADR;
                  OP_BGTZ:      curState <= BRANCH;
                  OP_J:         curState <= JUMP;
                  default:      curState <= FETCH;
               endcase
            end
            MEMADR: curState <= (opc == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (memReady) curState <= MEMWB;
            MEMWR:  if (memReady) curState <= FETCH;
            EXEC:   curState <= ALUWB;
            ADDIEX: curState <= ADDIWB;
            default: curState <= FETCH;
         endcase
      end
   end

   mc_out_decode #(
      .OP_W   (OP_W),
      .ALUC_W (ALUC_W)
   ) u_decode (
      .reset      (reset),
      .state      (curState),
      .op         (op),
      .memReady   (memReady),
      .gtz        (gtz),
      .IorD       (IorD),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .PCWrite    (PCWrite),
      .Branch     (Branch),
      .PCSrc      (PCSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUControl (ALUControl),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
      .illegal    (illegal)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: expected per-cycle control words are
// queued with their stimulus and compared as the FSM walks each instruction.
module tb_multicycle_control;

   localparam logic [5:0] T_ADD  = 6'b000000;
   localparam logic [5:0] T_ADDI = 6'b001000;
   localparam logic [5:0] T_LW   = 6'b100011;
   localparam logic [5:0] T_SW   = 6'b101011;
   localparam logic [5:0] T_BGTZ = 6'b000111;
   localparam logic [5:0] T_J    = 6'b000010;
   localparam logic [5:0] T_BAD  = 6'b111111;

   typedef struct packed {
      logic [3:0] st;
      logic       iord, mrd, mwr, irw, pcw, br;
      logic [1:0] pcsrc;
      logic       srca;
      logic [1:0] srcb;
      logic [2:0] aluc;
      logic       rdst, m2r, rw, ill;
   } ctrlT;

   typedef struct packed {
      logic       rst, mr, g;
      logic [5:0] op;
      ctrlT       exp;
   } entryT;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rst0 = 1'b1;
   logic [5:0] op = '0;
   logic mem_ready = 1'b1;
   logic gtz = 1'b0;

   logic IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA, RegDst, MemtoReg, RegWrite, illegal;
   logic [1:0] PCSrc, ALUSrcB;
   logic [2:0] ALUControl;
   logic [3:0] state;

   logic IorD0, MemRead0, MemWrite0, IRWrite0, PCWrite0, Branch0, ALUSrcA0, RegDst0, MemtoReg0, RegWrite0, illegal0;
   logic [1:0] PCSrc0, ALUSrcB0;
   logic [2:0] ALUControl0;
   logic [3:0] state0;

   ctrlT obs, obs0;
   entryT sb[$];
   int checkCount = 0;
   int passCount  = 0;
   int cycleIdx   = 0;

   always #5 clk = ~clk;

   multicycle_control #(.OP_W(6), .ALUC_W(3), .MEM_WAIT(1)) u_dut (
      .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .gtz(gtz),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .illegal(illegal), .state(state)
   );

   multicycle_control #(.OP_W(6), .ALUC_W(3), .MEM_WAIT(0)) u_dutNoWait (
      .clk(clk), .reset(rst0), .op(op), .mem_ready(1'b0), .gtz(gtz),
      .IorD(IorD0), .MemRead(MemRead0), .MemWrite(MemWrite0), .IRWrite(IRWrite0),
      .PCWrite(PCWrite0), .Branch(Branch0), .PCSrc(PCSrc0), .ALUSrcA(ALUSrcA0),
      .ALUSrcB(ALUSrcB0), .ALUControl(ALUControl0), .RegDst(RegDst0),
      .MemtoReg(MemtoReg0), .RegWrite(RegWrite0), .illegal(illegal0), .state(state0)
   );

   assign obs  = {state, IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch, PCSrc,
                  ALUSrcA, ALUSrcB, ALUControl, RegDst, MemtoReg, RegWrite, illegal};
   assign obs0 = {state0, IorD0, MemRead0, MemWrite0, IRWrite0, PCWrite0, Branch0, PCSrc0,
                  ALUSrcA0, ALUSrcB0, ALUControl0, RegDst0, MemtoReg0, RegWrite0, illegal0};

   // Expected control words per state, written straight from the state table.
   function automatic ctrlT base(input logic [3:0] st);
      ctrlT c;
      c      = '0;
      c.st   = st;
      c.aluc = 3'b111;
      return c;
   endfunction

   function automatic ctrlT eFetch(input logic strobe);
      ctrlT c;
      c = base(4'd0); c.mrd = 1'b1; c.srcb = 2'b01; c.irw = strobe; c.pcw = strobe;
      return c;
   endfunction

   function automatic ctrlT eDecode(input logic ill);
      ctrlT c;
      c = base(4'd1); c.srcb = 2'b11; c.ill = ill;
      return c;
   endfunction

   function automatic ctrlT eMemAdr();
      ctrlT c;
      c = base(4'd2); c.srca = 1'b1; c.srcb = 2'b10;
      return c;
   endfunction

   function automatic ctrlT eMemRd();
      ctrlT c;
      c = base(4'd3); c.iord = 1'b1; c.mrd = 1'b1;
      return c;
   endfunction

   function automatic ctrlT eMemWb();
      ctrlT c;
      c = base(4'd4); c.m2r = 1'b1; c.rw = 1'b1;
      return c;
   endfunction

   function automatic ctrlT eMemWr(input logic w);
      ctrlT c;
      c = base(4'd5); c.iord = 1'b1; c.mwr = w;
      return c;
   endfunction

   function automatic ctrlT eExec();
      ctrlT c;
      c = base(4'd6); c.srca = 1'b1;
      return c;
   endfunction

   function automatic ctrlT eAluWb();
      ctrlT c;
      c = base(4'd7); c.rdst = 1'b1; c.rw = 1'b1;
      return c;
   endfunction

   function automatic ctrlT eAddiEx();
      ctrlT c;
      c = base(4'd8); c.srca = 1'b1; c.srcb = 2'b10;
      return c;
   endfunction

   function automatic ctrlT eAddiWb();
      ctrlT c;
      c = base(4'd9); c.rw = 1'b1;
      return c;
   endfunction

   function automatic ctrlT eBranch(input logic g);
      ctrlT c;
      c = base(4'd10); c.srca = 1'b1; c.aluc = 3'b110; c.pcsrc = 2'b01; c.br = g;
      return c;
   endfunction

   function automatic ctrlT eJump();
      ctrlT c;
      c = base(4'd11); c.aluc = 3'b101; c.pcsrc = 2'b10; c.pcw = 1'b1;
      return c;
   endfunction

   task automatic check(input string tag, input ctrlT got, input ctrlT exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                    tag, got, got.st, exp, exp.st);
   endtask

   task automatic push(input logic rst, input logic mr, input logic g,
                       input logic [5:0] opc, input ctrlT exp);
      entryT e;
      e.rst = rst; e.mr = mr; e.g = g; e.op = opc; e.exp = exp;
      sb.push_back(e);
   endtask

   // Applies each queued stimulus just after a rising edge and compares on the falling edge.
   task automatic drain(input string tag, input bit noWait);
      entryT e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(posedge clk);
         #1;
         if (noWait) rst0 = e.rst;
         else        reset = e.rst;
         mem_ready = e.mr;
         gtz       = e.g;
         op        = e.op;
         @(negedge clk);
         check($sformatf("%s[%0d]", tag, cycleIdx), noWait ? obs0 : obs, e.exp);
         cycleIdx++;
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);

      // Reset held: FETCH state with write strobes suppressed.
      push(1, 1, 0, T_ADD, eFetch(0));
      drain("reset", 0);

      push(0, 1, 0, T_ADD, eFetch(1));
      push(0, 1, 0, T_ADD, eDecode(0));
      push(0, 1, 0, T_ADD, eExec());
      push(0, 1, 0, T_ADD, eAluWb());
      drain("add", 0);

      push(0, 1, 0, T_LW, eFetch(1));
      push(0, 1, 0, T_LW, eDecode(0));
      push(0, 1, 0, T_LW, eMemAdr());
      push(0, 1, 0, T_LW, eMemRd());
      push(0, 1, 0, T_LW, eMemWb());
      drain("lw", 0);

      push(0, 1, 0, T_SW, eFetch(1));
      push(0, 1, 0, T_SW, eDecode(0));
      push(0, 1, 0, T_SW, eMemAdr());
      for (int i = 0; i < 3; i++) push(0, 0, 0, T_SW, eMemWr(0));
      push(0, 1, 0, T_SW, eMemWr(1));
      drain("sw", 0);

      push(0, 1, 1, T_BGTZ, eFetch(1));
      push(0, 1, 1, T_BGTZ, eDecode(0));
      push(0, 1, 1, T_BGTZ, eBranch(1));
      push(0, 1, 0, T_BGTZ, eFetch(1));
      push(0, 1, 0, T_BGTZ, eDecode(0));
      push(0, 1, 0, T_BGTZ, eBranch(0));
      drain("bgtz", 0);

      push(0, 1, 0, T_J, eFetch(1));
      push(0, 1, 0, T_J, eDecode(0));
      push(0, 1, 0, T_J, eJump());
      drain("j", 0);

      push(0, 1, 0, T_BAD, eFetch(1));
      push(0, 1, 0, T_BAD, eDecode(1));
      drain("illegal", 0);

      // Fetch wait cycle after the illegal opcode, then addi.
      push(0, 0, 0, T_ADDI, eFetch(0));
      push(0, 1, 0, T_ADDI, eFetch(1));
      push(0, 1, 0, T_ADDI, eDecode(0));
      push(0, 1, 0, T_ADDI, eAddiEx());
      push(0, 1, 0, T_ADDI, eAddiWb());
      drain("addi", 0);

      // lw stalled in MEMRD, reset asserted mid-wait, then a jump after release.
      push(0, 1, 0, T_LW, eFetch(1));
      push(0, 1, 0, T_LW, eDecode(0));
      push(0, 1, 0, T_LW, eMemAdr());
      push(0, 0, 0, T_LW, eMemRd());
      push(1, 0, 0, T_LW, eMemRd());
      push(1, 0, 0, T_LW, eFetch(0));
      push(0, 1, 0, T_J, eFetch(1));
      push(0, 1, 0, T_J, eDecode(0));
      push(0, 1, 0, T_J, eJump());
      drain("rstwait", 0);

      // MEM_WAIT=0 instance with mem_ready tied low: add completes in 4 cycles.
      push(1, 0, 0, T_ADD, eFetch(0));
      push(0, 0, 0, T_ADD, eFetch(1));
      push(0, 0, 0, T_ADD, eDecode(0));
      push(0, 0, 0, T_ADD, eExec());
      push(0, 0, 0, T_ADD, eAluWb());
      push(0, 0, 0, T_ADD, eFetch(1));
      drain("nowait", 1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
